// File: rtl/packet_types.sv
// Packet-level types for the router input stage.
//
// arb_state_t : input arbiter FSM state (IDLE, LOCK_CPU, LOCK_NOC).
// src_t       : round-robin pointer encoding, 0 = CPU, 1 = NoC.
// opens_packet: true for flits that may start a grant (HEAD or SYSTEM).
// other_src   : the source the pointer moves to after a winner finishes.
package packet_types;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_CPU = 2'd1,
    LOCK_NOC = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_NOC = 1'b1
  } src_t;

  function automatic logic opens_packet(input types::flit_t f);
    return (f.header.flittype == types::HEAD) ||
           (f.header.flittype == types::SYSTEM);
  endfunction

  // The pointer always moves away from the source that just finished.
  function automatic src_t other_src(input logic winner_is_cpu);
    return winner_is_cpu ? SRC_NOC : SRC_CPU;
  endfunction

endpackage

// File: rtl/types.sv
// Shared flit definitions for the NoC.
//
// flit_t is a 48-bit packed flit: a 16-bit header carrying the flit class,
// source and destination node ids, followed by a 32-bit payload.
package types;

  // Flit class. HEAD opens a packet, BODY continues it, TAIL closes it and
  // SYSTEM is a complete single-flit packet.
  typedef enum logic [1:0] {
    HEAD   = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    SYSTEM = 2'd3
  } flittype_t;

  typedef struct packed {
    flittype_t   flittype;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [5:0]  rsvd;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
  } flit_t;

endpackage

// File: rtl/flit_fifo.sv
// First-word-fall-through flit FIFO with registered storage.
//
// Parameters:
//   DEPTH  entries, power of two, >= 2
// Ports:
//   nocclk  clock
//   rst_n   synchronous active-low reset; empties the FIFO
//   push    write request; ignored while full
//   flit    write data
//   pop     read request; ignored while empty
//   full    no free entry
//   empty   no stored entry
//   front   oldest stored flit, valid whenever !empty
//
// A flit written in cycle n shows up on front in cycle n+1, so a push and a
// pop can never meet on an empty FIFO. A push while full is refused even if a
// pop happens in the same cycle, matching a ready that was already low.
module flit_fifo
  import types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  nocclk,
  input  logic  rst_n,
  input  logic  push,
  input  flit_t flit,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output flit_t front
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  flit_t       mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign front = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers define
  // validity, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge nocclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= flit;
  end

endmodule

// File: rtl/router_input_arbiter.sv
// Packet-aware input stage in front of the router.
//
// Buffers flits from the local CPU and the NoC receiver in one FIFO each and
// grants one source at a time for a whole packet. A copy of the current
// packet's head flit is kept so the router can decode BODY and TAIL flits.
//
// Parameters:
//   DEPTH   entries per input FIFO (power of two, >= 2)
//   DROP_W  width of the saturating drop counter
// Ports:
//   nocclk                 clock
//   rst_n                  synchronous active-low reset
//   cpu_flit / _valid      CPU-side flit, handshake with cpu_flit_ready
//   cpu_flit_ready         CPU FIFO not full (0 while in reset)
//   noc_flit / _valid      NoC-receiver flit, handshake with noc_flit_ready
//   noc_flit_ready         NoC FIFO not full (0 while in reset)
//   transfered_flit        flit presented to the router
//   transfered_flit_valid  / transfered_flit_ready  handshake to the router
//   transfered_head_flit   head flit of the packet being transferred
//   is_flit_from_cpu       presented flit comes from the CPU FIFO
//   drop_count             orphan BODY/TAIL flits discarded, saturating
module router_input_arbiter
  import types::*;
  import packet_types::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              nocclk,
  input  logic              rst_n,
  input  flit_t             cpu_flit,
  input  logic              cpu_flit_valid,
  output logic              cpu_flit_ready,
  input  flit_t             noc_flit,
  input  logic              noc_flit_valid,
  output logic              noc_flit_ready,
  output flit_t             transfered_flit,
  output logic              transfered_flit_valid,
  input  logic              transfered_flit_ready,
  output flit_t             transfered_head_flit,
  output logic              is_flit_from_cpu,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  flit_t      cpu_front;
  flit_t      noc_front;
  logic       cpu_full;
  logic       cpu_empty;
  logic       cpu_pop;
  logic       noc_full;
  logic       noc_empty;
  logic       noc_pop;

  arb_state_t state;
  arb_state_t state_next;
  src_t       prio;
  src_t       prio_next;
  flit_t      head_reg;

  // A grant offered in IDLE but not yet accepted is remembered so that a new
  // candidate or the pointer cannot swap the presented source mid-stall.
  logic       pend;
  logic       pend_cpu;
  logic       pend_next;

  logic       cpu_open;
  logic       noc_open;
  logic       cpu_orphan;
  logic       noc_orphan;

  logic       sel_valid;
  logic       sel_cpu;
  flit_t      sel_front;
  logic       valid_out;
  logic       hs;
  logic       head_load;
  logic       discard_cpu;
  logic       discard_noc;

  // Ready is held low while in reset so no flit is accepted into a FIFO
  // that is being flushed.
  assign cpu_flit_ready = rst_n && !cpu_full;
  assign noc_flit_ready = rst_n && !noc_full;

  flit_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
    .nocclk (nocclk),
    .rst_n  (rst_n),
    .push   (cpu_flit_valid && cpu_flit_ready),
    .flit   (cpu_flit),
    .pop    (cpu_pop),
    .full   (cpu_full),
    .empty  (cpu_empty),
    .front  (cpu_front)
  );

  flit_fifo #(.DEPTH(DEPTH)) u_noc_fifo (
    .nocclk (nocclk),
    .rst_n  (rst_n),
    .push   (noc_flit_valid && noc_flit_ready),
    .flit   (noc_flit),
    .pop    (noc_pop),
    .full   (noc_full),
    .empty  (noc_empty),
    .front  (noc_front)
  );

  // Front-of-FIFO classification. An orphan is a BODY or TAIL seen while no
  // packet from that source is open.
  assign cpu_open   = !cpu_empty &&  opens_packet(cpu_front);
  assign noc_open   = !noc_empty &&  opens_packet(noc_front);
  assign cpu_orphan = !cpu_empty && !opens_packet(cpu_front);
  assign noc_orphan = !noc_empty && !opens_packet(noc_front);

  always_ff @(posedge nocclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    prio_next   = prio;
    head_load   = 1'b0;
    sel_valid   = 1'b0;
    sel_cpu     = 1'b1;
    discard_cpu = 1'b0;
    discard_noc = 1'b0;

    case (state)
      IDLE: begin
        // One discard per cycle, CPU side first. Discards use the FIFO pop
        // only, never the router handshake.
        discard_cpu = cpu_orphan;
        discard_noc = noc_orphan && !cpu_orphan;

        if (pend) begin
          sel_valid = 1'b1;
          sel_cpu   = pend_cpu;
        end else if (cpu_open && noc_open) begin
          sel_valid = 1'b1;
          sel_cpu   = (prio == SRC_CPU);
        end else if (cpu_open) begin
          sel_valid = 1'b1;
          sel_cpu   = 1'b1;
        end else if (noc_open) begin
          sel_valid = 1'b1;
          sel_cpu   = 1'b0;
        end
      end
      LOCK_CPU: begin
        sel_valid = !cpu_empty;
        sel_cpu   = 1'b1;
      end
      LOCK_NOC: begin
        sel_valid = !noc_empty;
        sel_cpu   = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    sel_front = sel_cpu ? cpu_front : noc_front;
    valid_out = sel_valid && rst_n;
    hs        = valid_out && transfered_flit_ready;

    if (hs) begin
      case (sel_front.header.flittype)
        HEAD: begin
          // In a locked state this is a new packet after a lost tail: the
          // head copy is refreshed and the lock is kept.
          head_load = 1'b1;
          if (state == IDLE) state_next = sel_cpu ? LOCK_CPU : LOCK_NOC;
        end
        SYSTEM: begin
          // Inside a lock a SYSTEM flit passes through without touching
          // the head copy or the pointer.
          if (state == IDLE) prio_next = other_src(sel_cpu);
        end
        TAIL: begin
          if (state != IDLE) begin
            state_next = IDLE;
            prio_next  = other_src(sel_cpu);
          end
        end
        default: ;
      endcase
    end

    pend_next = (state == IDLE) && valid_out && !transfered_flit_ready;
    cpu_pop   = (hs &&  sel_cpu) || discard_cpu;
    noc_pop   = (hs && !sel_cpu) || discard_noc;
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      prio       <= SRC_CPU;
      head_reg   <= '0;
      drop_count <= '0;
      pend       <= 1'b0;
      pend_cpu   <= 1'b0;
    end else begin
      prio     <= prio_next;
      pend     <= pend_next;
      pend_cpu <= sel_cpu;
      if (head_load) head_reg <= sel_front;
      if ((discard_cpu || discard_noc) && (drop_count != '1))
        drop_count <= drop_count + DROP_ONE;
    end
  end

  assign transfered_flit       = sel_front;
  assign transfered_flit_valid = valid_out;
  assign transfered_head_flit  = opens_packet(sel_front) ? sel_front : head_reg;
  assign is_flit_from_cpu      = sel_cpu;

endmodule

// File: tb/tb_router_input_arbiter.sv
// Self-checking bench for router_input_arbiter.
//
// A cycle-level reference model (per-source queues plus a lock/pointer view
// of the arbitration rules) predicts every output each cycle; scenario tasks
// add their own expectations on the accepted output stream.
module tb_router_input_arbiter;
  import types::*;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic              nocclk;
  logic              rst_n;
  flit_t             cpu_flit;
  logic              cpu_flit_valid;
  logic              cpu_flit_ready;
  flit_t             noc_flit;
  logic              noc_flit_valid;
  logic              noc_flit_ready;
  flit_t             transfered_flit;
  logic              transfered_flit_valid;
  logic              transfered_flit_ready;
  flit_t             transfered_head_flit;
  logic              is_flit_from_cpu;
  logic [DROP_W-1:0] drop_count;

  router_input_arbiter #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .nocclk                (nocclk),
    .rst_n                 (rst_n),
    .cpu_flit              (cpu_flit),
    .cpu_flit_valid        (cpu_flit_valid),
    .cpu_flit_ready        (cpu_flit_ready),
    .noc_flit              (noc_flit),
    .noc_flit_valid        (noc_flit_valid),
    .noc_flit_ready        (noc_flit_ready),
    .transfered_flit       (transfered_flit),
    .transfered_flit_valid (transfered_flit_valid),
    .transfered_flit_ready (transfered_flit_ready),
    .transfered_head_flit  (transfered_head_flit),
    .is_flit_from_cpu      (is_flit_from_cpu),
    .drop_count            (drop_count)
  );

  initial nocclk = 1'b0;
  always #5 nocclk = ~nocclk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: what each FIFO holds, which source owns the output
  // (0 none, 1 cpu, 2 noc), the round-robin pointer (1 = NoC), head copy,
  // drop total and a remembered unaccepted IDLE grant.
  flit_t m_cpu[$];
  flit_t m_noc[$];
  int    m_lock;
  bit    m_prio;
  flit_t m_head;
  int    m_drops;
  bit    m_pend;
  bit    m_pend_cpu;

  // Flits waiting to be offered by each source.
  flit_t s_cpu[$];
  flit_t s_noc[$];

  // Flits the DUT handed to the router (as observed on its outputs).
  flit_t lg_flit[$];
  bit    lg_cpu[$];
  flit_t lg_head[$];
  int    lg_cyc[$];

  bit    prev_stall;
  flit_t prev_flit;
  flit_t prev_head;
  bit    prev_cpu;

  function automatic flit_t mk(input flittype_t t, input logic [3:0] dst);
    flit_t f;
    f                 = '0;
    f.header.flittype = t;
    f.header.dst      = dst;
    f.payload         = $urandom;
    return f;
  endfunction

  function automatic bit opens(input flit_t f);
    return (f.header.flittype == HEAD) || (f.header.flittype == SYSTEM);
  endfunction

  task automatic clear_log();
    lg_flit.delete();
    lg_cpu.delete();
    lg_head.delete();
    lg_cyc.delete();
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance
  // the model across the rising edge. Entered and left on a falling edge.
  task automatic clock_cycle(input bit rst, input bit rdy, input bit cen, input bit nen);
    bit                e_valid;
    bit                e_cpu;
    bit                e_dcpu;
    bit                e_dnoc;
    bit                e_cr;
    bit                e_nr;
    bit                cand_c;
    bit                cand_n;
    bit                hs;
    bit                acc_c;
    bit                acc_n;
    flit_t             e_flit;
    flit_t             e_head;
    logic [DROP_W-1:0] e_drop;

    rst_n                 = !rst;
    cpu_flit_valid        = cen && (s_cpu.size() > 0);
    cpu_flit              = (s_cpu.size() > 0) ? s_cpu[0] : '0;
    noc_flit_valid        = nen && (s_noc.size() > 0);
    noc_flit              = (s_noc.size() > 0) ? s_noc[0] : '0;
    transfered_flit_ready = rdy;
    #1;

    e_valid = 1'b0;
    e_cpu   = 1'b1;
    e_dcpu  = 1'b0;
    e_dnoc  = 1'b0;
    e_flit  = '0;
    e_head  = '0;
    e_cr    = !rst && (m_cpu.size() < DEPTH);
    e_nr    = !rst && (m_noc.size() < DEPTH);
    e_drop  = m_drops[DROP_W-1:0];
    if (!rst) begin
      if (m_lock == 1) begin
        e_valid = m_cpu.size() > 0;
      end else if (m_lock == 2) begin
        e_valid = m_noc.size() > 0;
        e_cpu   = 1'b0;
      end else begin
        cand_c = (m_cpu.size() > 0) && opens(m_cpu[0]);
        cand_n = (m_noc.size() > 0) && opens(m_noc[0]);
        e_dcpu = (m_cpu.size() > 0) && !cand_c;
        e_dnoc = (m_noc.size() > 0) && !cand_n && !e_dcpu;
        if (m_pend) begin
          e_valid = 1'b1;
          e_cpu   = m_pend_cpu;
        end else if (cand_c && cand_n) begin
          e_valid = 1'b1;
          e_cpu   = !m_prio;
        end else if (cand_c) begin
          e_valid = 1'b1;
        end else if (cand_n) begin
          e_valid = 1'b1;
          e_cpu   = 1'b0;
        end
      end
    end
    if (e_valid) begin
      e_flit = e_cpu ? m_cpu[0] : m_noc[0];
      e_head = opens(e_flit) ? e_flit : m_head;
    end

    checks++;
    if (transfered_flit_valid !== e_valid) begin
      errors++;
      $display("FAIL valid cyc=%0d: got %b, expected %b", cyc, transfered_flit_valid, e_valid);
    end
    checks++;
    if (cpu_flit_ready !== e_cr) begin
      errors++;
      $display("FAIL cpu_ready cyc=%0d: got %b, expected %b", cyc, cpu_flit_ready, e_cr);
    end
    checks++;
    if (noc_flit_ready !== e_nr) begin
      errors++;
      $display("FAIL noc_ready cyc=%0d: got %b, expected %b", cyc, noc_flit_ready, e_nr);
    end
    checks++;
    if (drop_count !== e_drop) begin
      errors++;
      $display("FAIL drop_count cyc=%0d: got %0d, expected %0d", cyc, drop_count, e_drop);
    end
    if (e_valid && transfered_flit_valid) begin
      checks++;
      if (transfered_flit !== e_flit) begin
        errors++;
        $display("FAIL flit cyc=%0d: got %h, expected %h", cyc, transfered_flit, e_flit);
      end
      checks++;
      if (transfered_head_flit !== e_head) begin
        errors++;
        $display("FAIL head_flit cyc=%0d: got %h, expected %h", cyc, transfered_head_flit, e_head);
      end
      checks++;
      if (is_flit_from_cpu !== e_cpu) begin
        errors++;
        $display("FAIL from_cpu cyc=%0d: got %b, expected %b", cyc, is_flit_from_cpu, e_cpu);
      end
    end
    if (prev_stall && !rst) begin
      checks++;
      if (transfered_flit_valid !== 1'b1 || transfered_flit !== prev_flit ||
          transfered_head_flit !== prev_head || is_flit_from_cpu !== prev_cpu) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: got v=%b %h, expected v=1 %h",
                 cyc, transfered_flit_valid, transfered_flit, prev_flit);
      end
    end

    if (transfered_flit_valid === 1'b1 && rdy) begin
      lg_flit.push_back(transfered_flit);
      lg_cpu.push_back(is_flit_from_cpu);
      lg_head.push_back(transfered_head_flit);
      lg_cyc.push_back(cyc);
    end
    prev_stall = (transfered_flit_valid === 1'b1) && !rdy && !rst;
    prev_flit  = transfered_flit;
    prev_head  = transfered_head_flit;
    prev_cpu   = is_flit_from_cpu;

    hs    = e_valid && rdy;
    acc_c = cpu_flit_valid && e_cr;
    acc_n = noc_flit_valid && e_nr;

    @(posedge nocclk);
    cyc++;
    if (rst) begin
      m_cpu.delete();
      m_noc.delete();
      m_lock     = 0;
      m_prio     = 1'b0;
      m_head     = '0;
      m_drops    = 0;
      m_pend     = 1'b0;
      m_pend_cpu = 1'b0;
      prev_stall = 1'b0;
    end else begin
      m_pend     = (m_lock == 0) && e_valid && !rdy;
      m_pend_cpu = e_cpu;
      if (hs) begin
        if (e_cpu) void'(m_cpu.pop_front());
        else       void'(m_noc.pop_front());
        case (e_flit.header.flittype)
          HEAD: begin
            m_head = e_flit;
            if (m_lock == 0) m_lock = e_cpu ? 1 : 2;
          end
          SYSTEM: if (m_lock == 0) m_prio = e_cpu;
          TAIL: if (m_lock != 0) begin
            m_prio = (m_lock == 1);
            m_lock = 0;
          end
          default: ;
        endcase
      end
      if (e_dcpu) void'(m_cpu.pop_front());
      if (e_dnoc) void'(m_noc.pop_front());
      if ((e_dcpu || e_dnoc) && m_drops < 255) m_drops++;
      if (acc_c) begin
        m_cpu.push_back(cpu_flit);
        void'(s_cpu.pop_front());
      end
      if (acc_n) begin
        m_noc.push_back(noc_flit);
        void'(s_noc.pop_front());
      end
    end
    @(negedge nocclk);
  endtask

  task automatic do_reset();
    s_cpu.delete();
    s_noc.delete();
    clock_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    clock_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    rst_n                 = 1'b1;
    cpu_flit_valid        = 1'b0;
    noc_flit_valid        = 1'b0;
    transfered_flit_ready = 1'b1;
    #1;
    checks++;
    if (transfered_flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, expected 0", transfered_flit_valid);
    end
    checks++;
    if (cpu_flit_ready !== 1'b1 || noc_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got cpu=%b noc=%b, expected 1 1", cpu_flit_ready, noc_flit_ready);
    end
    checks++;
    if (drop_count !== '0) begin
      errors++;
      $display("FAIL reset_drop: got %0d, expected 0", drop_count);
    end
  endtask

  task automatic test_cpu_packet();
    flit_t pkt[4];
    int    t0;
    do_reset();
    pkt[0] = mk(HEAD, 4'd3);
    pkt[1] = mk(BODY, 4'd3);
    pkt[2] = mk(BODY, 4'd3);
    pkt[3] = mk(TAIL, 4'd3);
    for (int i = 0; i < 4; i++) s_cpu.push_back(pkt[i]);
    t0 = cyc;
    for (int i = 0; i < 8; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (lg_flit.size() != 4) begin
      errors++;
      $display("FAIL cpu_pkt_count: got %0d, expected 4", lg_flit.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (lg_flit[i] !== pkt[i] || lg_cpu[i] !== 1'b1 || lg_head[i] !== pkt[0] ||
            lg_cyc[i] != t0 + 1 + i) begin
          errors++;
          $display("FAIL cpu_pkt_%0d: got %h src=%b head=%h cyc=%0d, expected %h src=1 head=%h cyc=%0d",
                   i, lg_flit[i], lg_cpu[i], lg_head[i], lg_cyc[i], pkt[i], pkt[0], t0 + 1 + i);
        end
      end
    end
  endtask

  task automatic test_contention();
    flit_t exp_f[$];
    bit    exp_c[$];
    flit_t c[5];
    flit_t n[3];
    do_reset();
    c[0] = mk(HEAD, 4'd1); c[1] = mk(BODY, 4'd1); c[2] = mk(TAIL, 4'd1);
    c[3] = mk(HEAD, 4'd5); c[4] = mk(TAIL, 4'd5);
    n[0] = mk(HEAD, 4'd2); n[1] = mk(BODY, 4'd2); n[2] = mk(TAIL, 4'd2);
    for (int i = 0; i < 5; i++) s_cpu.push_back(c[i]);
    for (int i = 0; i < 3; i++) s_noc.push_back(n[i]);
    for (int i = 0; i < 3; i++) begin exp_f.push_back(c[i]); exp_c.push_back(1'b1); end
    for (int i = 0; i < 3; i++) begin exp_f.push_back(n[i]); exp_c.push_back(1'b0); end
    for (int i = 3; i < 5; i++) begin exp_f.push_back(c[i]); exp_c.push_back(1'b1); end
    for (int i = 0; i < 14; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (lg_flit.size() != exp_f.size()) begin
      errors++;
      $display("FAIL contention_count: got %0d, expected %0d", lg_flit.size(), exp_f.size());
    end else begin
      for (int i = 0; i < exp_f.size(); i++) begin
        checks++;
        if (lg_flit[i] !== exp_f[i] || lg_cpu[i] !== exp_c[i]) begin
          errors++;
          $display("FAIL contention_%0d: got %h src=%b, expected %h src=%b",
                   i, lg_flit[i], lg_cpu[i], exp_f[i], exp_c[i]);
        end
      end
      checks++;
      if (lg_cyc[3] != lg_cyc[2] + 1) begin
        errors++;
        $display("FAIL contention_gap: got noc head at %0d, expected %0d", lg_cyc[3], lg_cyc[2] + 1);
      end
    end
  endtask

  task automatic test_system_interleave();
    flit_t exp_f[$];
    bit    exp_c[$];
    flit_t sys0;
    flit_t sys1;
    flit_t c[3];
    flit_t n[2];
    do_reset();
    // A CPU SYSTEM flit first moves the pointer to the NoC.
    sys0 = mk(SYSTEM, 4'd7);
    s_cpu.push_back(sys0);
    for (int i = 0; i < 3; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    clear_log();
    sys1 = mk(SYSTEM, 4'd8);
    c[0] = mk(HEAD, 4'd9); c[1] = mk(BODY, 4'd9); c[2] = mk(TAIL, 4'd9);
    n[0] = mk(HEAD, 4'd6); n[1] = mk(TAIL, 4'd6);
    s_noc.push_back(sys1);
    s_noc.push_back(n[0]);
    s_noc.push_back(n[1]);
    for (int i = 0; i < 3; i++) s_cpu.push_back(c[i]);
    exp_f.push_back(sys1); exp_c.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin exp_f.push_back(c[i]); exp_c.push_back(1'b1); end
    for (int i = 0; i < 2; i++) begin exp_f.push_back(n[i]); exp_c.push_back(1'b0); end
    for (int i = 0; i < 10; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (lg_flit.size() != exp_f.size()) begin
      errors++;
      $display("FAIL sys_count: got %0d, expected %0d", lg_flit.size(), exp_f.size());
    end else begin
      checks++;
      if (lg_head[0] !== sys1) begin
        errors++;
        $display("FAIL sys_head: got %h, expected %h", lg_head[0], sys1);
      end
      for (int i = 0; i < exp_f.size(); i++) begin
        checks++;
        if (lg_flit[i] !== exp_f[i] || lg_cpu[i] !== exp_c[i]) begin
          errors++;
          $display("FAIL sys_order_%0d: got %h src=%b, expected %h src=%b",
                   i, lg_flit[i], lg_cpu[i], exp_f[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_orphan();
    do_reset();
    s_noc.push_back(mk(TAIL, 4'd2));
    for (int i = 0; i < 3; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (drop_count !== 8'd1 || lg_flit.size() != 0) begin
      errors++;
      $display("FAIL orphan_one: got drops=%0d out=%0d, expected drops=1 out=0", drop_count, lg_flit.size());
    end
    for (int i = 0; i < 300; i++) s_noc.push_back(mk(($urandom_range(0, 1) != 0) ? BODY : TAIL, 4'd2));
    for (int i = 0; i < 305; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (drop_count !== 8'hFF || lg_flit.size() != 0) begin
      errors++;
      $display("FAIL orphan_sat: got drops=%0d out=%0d, expected drops=255 out=0", drop_count, lg_flit.size());
    end
  endtask

  task automatic test_backpressure();
    flit_t pkt[9];
    bit    saw_full;
    do_reset();
    pkt[0] = mk(HEAD, 4'd4);
    for (int i = 1; i < 8; i++) pkt[i] = mk(BODY, 4'd4);
    pkt[8] = mk(TAIL, 4'd4);
    for (int i = 0; i < 9; i++) s_cpu.push_back(pkt[i]);
    saw_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clock_cycle(1'b0, !(i >= 3 && i < 8), 1'b1, 1'b1);
      if (i == 7 && m_cpu.size() == DEPTH) saw_full = 1'b1;
      if (i == 7 && cpu_flit_ready !== 1'b0) saw_full = 1'b0;
    end
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL bp_fill: got ready=%b, expected cpu fifo full with ready 0", cpu_flit_ready);
    end
    checks++;
    if (lg_flit.size() != 9) begin
      errors++;
      $display("FAIL bp_count: got %0d, expected 9", lg_flit.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (lg_flit[i] !== pkt[i] || lg_head[i] !== pkt[0]) begin
          errors++;
          $display("FAIL bp_flit_%0d: got %h, expected %h", i, lg_flit[i], pkt[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    s_cpu.push_back(mk(HEAD, 4'd1));
    s_cpu.push_back(mk(BODY, 4'd1));
    s_cpu.push_back(mk(BODY, 4'd1));
    for (int i = 0; i < 3; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    clock_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    s_cpu.delete();
    clear_log();
    rst_n                 = 1'b1;
    cpu_flit_valid        = 1'b0;
    noc_flit_valid        = 1'b0;
    transfered_flit_ready = 1'b1;
    #1;
    checks++;
    if (transfered_flit_valid !== 1'b0 || cpu_flit_ready !== 1'b1 || noc_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_flush: got v=%b cr=%b nr=%b, expected 0 1 1",
               transfered_flit_valid, cpu_flit_ready, noc_flit_ready);
    end
    s_cpu.push_back(mk(TAIL, 4'd1));
    for (int i = 0; i < 4; i++) clock_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (drop_count !== 8'd1 || lg_flit.size() != 0) begin
      errors++;
      $display("FAIL midrst_tail: got drops=%0d out=%0d, expected drops=1 out=0", drop_count, lg_flit.size());
    end
  endtask

  task automatic gen_stream(input bit to_cpu, input int units);
    flit_t   q[$];
    int      r;
    int      nb;
    logic [3:0] d;
    for (int u = 0; u < units; u++) begin
      r = $urandom_range(0, 99);
      d = 4'($urandom_range(0, 15));
      if (r < 25) begin
        q.push_back(mk(SYSTEM, d));
      end else if (r < 80) begin
        nb = $urandom_range(0, 3);
        q.push_back(mk(HEAD, d));
        for (int b = 0; b < nb; b++) q.push_back(mk(BODY, d));
        q.push_back(mk(TAIL, d));
      end else if (r < 90) begin
        q.push_back(mk(($urandom_range(0, 1) != 0) ? BODY : TAIL, d));
      end else begin
        q.push_back(mk(HEAD, d));
      end
    end
    // Close any lost-tail lock so the stream always drains.
    q.push_back(mk(HEAD, 4'd0));
    q.push_back(mk(TAIL, 4'd0));
    foreach (q[i]) begin
      if (to_cpu) s_cpu.push_back(q[i]);
      else        s_noc.push_back(q[i]);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    gen_stream(1'b1, 30);
    gen_stream(1'b0, 30);
    n = 0;
    while ((s_cpu.size() + s_noc.size() + m_cpu.size() + m_noc.size()) != 0 && n < 4000) begin
      clock_cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL random_drain: got %0d flits left, expected 0",
               s_cpu.size() + s_noc.size() + m_cpu.size() + m_noc.size());
    end
    clock_cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n                 = 1'b0;
    cpu_flit              = '0;
    cpu_flit_valid        = 1'b0;
    noc_flit              = '0;
    noc_flit_valid        = 1'b0;
    transfered_flit_ready = 1'b0;
    prev_stall            = 1'b0;
    test_reset();
    test_cpu_packet();
    test_contention();
    test_system_interleave();
    test_orphan();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
